// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand feeder: operand width,
// default WAIT timeout and the feeder FSM state encoding.
package mul_pkg;

   localparam int OP_W            = 16;
   localparam int TIMEOUT_DEFAULT = 70000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_SEND_A = 3'd2,
      ST_SEND_B = 3'd3,
      ST_WAIT   = 3'd4,
      ST_DRAIN  = 3'd5
   } state_t;

   // Counter width able to hold every value up to and including max_count.
   function automatic int ctr_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/mul_timeout_ctr.sv
// Cycle counter for the feeder's WAIT state: cleared while idle, counts while
// enabled and flags the last permitted cycle (LIMIT-1).
module mul_timeout_ctr
   import mul_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int              CW   = ctr_width(LIMIT);
   localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

   logic [CW-1:0] r_count;

   // Saturates at LAST so a stalled enable can never wrap back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/mul_operand_feeder.sv
// Accepts an operand pair, streams it to a shift-add multiplier over a shared
// bus (0, A, B), waits for done or timeout, and holds one result for handoff.
module mul_operand_feeder
   import mul_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] in_a,
   input  logic [OP_W-1:0] in_b,
   output logic            mul_start,
   output logic [OP_W-1:0] mul_data,
   input  logic            mul_done,
   input  logic [OP_W-1:0] mul_prod,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] out_prod,
   output logic            out_err
);

   state_t          r_state;
   state_t          w_state_next;
   logic [OP_W-1:0] r_a;
   logic [OP_W-1:0] r_b;
   logic            r_out_valid;
   logic [OP_W-1:0] r_out_prod;
   logic            r_out_err;

   logic w_idle_free;
   logic w_accept;
   logic w_zero_op;
   logic w_in_wait;
   logic w_tc;
   logic w_done_cap;
   logic w_abort;
   logic w_handoff;

   assign w_idle_free = (r_state == ST_IDLE) && !r_out_valid;
   assign w_accept    = in_valid && w_idle_free;
   assign w_zero_op   = (in_a == '0) || (in_b == '0);
   assign w_in_wait   = (r_state == ST_WAIT);
   assign w_done_cap  = w_in_wait && mul_done;
   assign w_abort     = w_in_wait && !mul_done && w_tc;
   assign w_handoff   = r_out_valid && out_ready;

   // rst_n gates only the port so the producer never sees ready during reset.
   assign in_ready    = rst_n && w_idle_free;

   mul_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_timeout_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (!w_in_wait),
      .i_enable   (w_in_wait),
      .o_terminal (w_tc)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept && !w_zero_op) w_state_next = ST_START;
         ST_START:  w_state_next = ST_SEND_A;
         ST_SEND_A: w_state_next = ST_SEND_B;
         ST_SEND_B: w_state_next = ST_WAIT;
         ST_WAIT:   if (mul_done || w_tc) w_state_next = ST_DRAIN;
         ST_DRAIN:  if (!mul_done) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_accept) begin
         r_a <= in_a;
         r_b <= in_b;
      end
   end

   // A new result can only be loaded while out_valid is low, so load and
   // handoff never collide; done takes precedence over the timeout abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_prod  <= '0;
         r_out_err   <= 1'b0;
      end else if (w_accept && w_zero_op) begin
         r_out_valid <= 1'b1;
         r_out_prod  <= '0;
         r_out_err   <= 1'b0;
      end else if (w_done_cap) begin
         r_out_valid <= 1'b1;
         r_out_prod  <= mul_prod;
         r_out_err   <= 1'b0;
      end else if (w_abort) begin
         r_out_valid <= 1'b1;
         r_out_prod  <= '0;
         r_out_err   <= 1'b1;
      end else if (w_handoff) begin
         r_out_valid <= 1'b0;
         r_out_prod  <= '0;
         r_out_err   <= 1'b0;
      end
   end

   always_comb begin
      mul_start = 1'b0;
      mul_data  = '0;
      case (r_state)
         ST_START:  mul_start = 1'b1;
         ST_SEND_A: mul_data  = r_a;
         ST_SEND_B: mul_data  = r_b;
         default:   ;
      endcase
   end

   assign out_valid = r_out_valid;
   assign out_prod  = r_out_prod;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Self-checking bench for mul_operand_feeder: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mul_operand_feeder;

   localparam int TMO = 20;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        mul_start;
   logic [15:0] mul_data;
   logic        mul_done;
   logic [15:0] mul_prod;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_prod;
   logic        out_err;

   int n_vec    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int cfg_lat  = 0;
   int cfg_hold = 1;
   int or_mode  = 0;

   typedef struct packed {
      logic [15:0] prod;
      logic        err;
   } res_t;

   res_t exp_q[$];

   mul_operand_feeder #(
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_start (mul_start),
      .mul_data  (mul_data),
      .mul_done  (mul_done),
      .mul_prod  (mul_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_err   (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Consumer: 0 = stall, 1 = always ready, otherwise random back-pressure.
   initial begin : consumer
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Multiplier: takes A and B from the bus after mul_start, raises done
   // during WAIT cycle cfg_lat (never if negative), holds it cfg_hold cycles.
   initial begin : mul_model
      int          l;
      int          h;
      logic [15:0] ma;
      logic [15:0] mb;
      mul_done = 1'b0;
      mul_prod = 16'($urandom);
      forever begin
         @(negedge clk);
         if (rst_n && mul_start) begin
            l = cfg_lat;
            h = cfg_hold;
            @(negedge clk);
            ma = mul_data;
            @(negedge clk);
            mb = mul_data;
            if (l >= 0) begin
               repeat (l + 1) @(posedge clk);
               #1;
               mul_done = 1'b1;
               mul_prod = 16'(32'(ma) * 32'(mb));
               repeat (h) @(posedge clk);
               #1;
               mul_done = 1'b0;
               mul_prod = 16'($urandom);
            end
         end
      end
   end

   // Per-cycle compare: expected bus schedule after each accept and the
   // expected result of every accepted pair, in order.
   initial begin : compare
      int          sched;
      logic [15:0] sa;
      logic [15:0] sb;
      bit          prev_hs;
      res_t        r;
      sched   = 0;
      sa      = '0;
      sb      = '0;
      prev_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            sched   = 0;
            prev_hs = 1'b0;
         end else begin
            chk("mul_start", 32'(mul_start), 32'(sched == 1));
            chk("mul_data", 32'(mul_data),
                (sched == 2) ? 32'(sa) : (sched == 3) ? 32'(sb) : 32'd0);
            sched = (sched == 0 || sched == 3) ? 0 : sched + 1;
            if (prev_hs) chk("out_valid_cleared", 32'(out_valid), 32'd0);
            if (in_ready) chk("in_ready_with_result", 32'(out_valid), 32'd0);
            prev_hs = 1'b0;
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 32'(out_valid), 32'd0);
               end else begin
                  chk("out_prod", 32'(out_prod), 32'(exp_q[0].prod));
                  chk("out_err", 32'(out_err), 32'(exp_q[0].err));
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     prev_hs = 1'b1;
                  end
               end
            end
            if (in_valid && in_ready) begin
               if (in_a == 16'd0 || in_b == 16'd0) begin
                  r.prod = 16'd0;
                  r.err  = 1'b0;
               end else begin
                  sched = 1;
                  sa    = in_a;
                  sb    = in_b;
                  if (cfg_lat < 0 || cfg_lat >= TMO) begin
                     r.prod = 16'd0;
                     r.err  = 1'b1;
                  end else begin
                     r.prod = 16'(32'(in_a) * 32'(in_b));
                     r.err  = 1'b0;
                  end
               end
               exp_q.push_back(r);
            end
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input int lat, input int hold, output int acc);
      bit ok;
      ok  = 1'b0;
      acc = -1;
      @(posedge clk);
      #1;
      cfg_lat  = lat;
      cfg_hold = hold;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok  = 1'b1;
            acc = cyc;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
   endtask

   task automatic wait_out(output int at);
      at = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("result_timeout", 32'(out_valid), 32'd1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required $finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int acc;
      int at;
      int hi;
      bit seen;
      logic [15:0] ra;
      logic [15:0] rb;
      int rl;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      or_mode  = 0;

      #12;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_mul_data",  32'(mul_data),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_prod",  32'(out_prod),  32'd0);
      chk("rst_out_err",   32'(out_err),   32'd0);

      // Release reset mid-cycle with a pair already offered: accepted on the
      // very next rising edge.
      @(posedge clk);
      #2;
      cfg_lat  = 3;
      cfg_hold = 1;
      in_a     = 16'd17;
      in_b     = 16'd5;
      in_valid = 1'b1;
      rst_n    = 1'b1;
      @(negedge clk);
      chk("first_accept_ready", 32'(in_ready), 32'd1);
      acc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("seq_start_pulse", 32'(mul_start), 32'd1);
      chk("seq_data0", 32'(mul_data), 32'd0);
      @(negedge clk);
      chk("seq_start_low", 32'(mul_start), 32'd0);
      chk("seq_dataA", 32'(mul_data), 32'd17);
      @(negedge clk);
      chk("seq_dataB", 32'(mul_data), 32'd5);
      wait_out(at);
      chk("lat_17x5", 32'(at - acc), 32'd8);
      chk("prod_17x5", 32'(out_prod), 32'd85);
      chk("err_17x5", 32'(out_err), 32'd0);

      // Back-pressure: result held, pending pair refused.
      @(posedge clk);
      #1;
      cfg_lat  = 5;
      cfg_hold = 1;
      in_a     = 16'd6;
      in_b     = 16'd7;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_prod", 32'(out_prod), 32'd85);
      end
      or_mode = 1;
      seen    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready) begin
            seen = 1'b1;
            acc  = cyc;
            break;
         end
      end
      chk("accept_after_handoff", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(at);
      chk("lat_6x7", 32'(at - acc), 32'd10);
      chk("prod_6x7", 32'(out_prod), 32'd42);

      // Zero operand: immediate result, multiplier untouched.
      send(16'd0, 16'd9, 3, 1, acc);
      wait_out(at);
      chk("zero_lat", 32'(at - acc), 32'd1);
      chk("zero_prod", 32'(out_prod), 32'd0);
      chk("zero_err", 32'(out_err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("zero_no_start", 32'(mul_start), 32'd0);
      end

      // Timeout: never done.
      send(16'd7, 16'd9, -1, 1, acc);
      wait_out(at);
      chk("tmo_lat", 32'(at - acc), 32'd24);
      chk("tmo_prod", 32'(out_prod), 32'd0);
      chk("tmo_err", 32'(out_err), 32'd1);

      // Done on the last permitted WAIT cycle beats the timeout.
      send(16'd11, 16'd13, TMO - 1, 1, acc);
      wait_out(at);
      chk("edge_lat", 32'(at - acc), 32'd24);
      chk("edge_prod", 32'(out_prod), 32'd143);
      chk("edge_err", 32'(out_err), 32'd0);

      // Done held for 5 cycles keeps the feeder draining.
      send(16'd9, 16'd3, 2, 5, acc);
      hi   = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mul_done) begin
            hi++;
            chk("drain_in_ready", 32'(in_ready), 32'd0);
         end else if (hi > 0) begin
            chk("drain_last_cycle", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("drain_exit_ready", 32'(in_ready), 32'd1);
            seen = 1'b1;
            break;
         end
      end
      chk("drain_done_cycles", 32'(hi), 32'd5);
      chk("drain_exit_seen", 32'(seen), 32'd1);

      // Asynchronous reset in WAIT discards everything.
      send(16'd300, 16'd2, -1, 1, acc);
      repeat (6) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready",  32'(in_ready),  32'd0);
      chk("arst_mul_start", 32'(mul_start), 32'd0);
      chk("arst_mul_data",  32'(mul_data),  32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_prod",  32'(out_prod),  32'd0);
      chk("arst_out_err",   32'(out_err),   32'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      send(16'd3, 16'd4, 2, 1, acc);
      wait_out(at);
      chk("post_rst_prod", 32'(out_prod), 32'd12);
      chk("post_rst_err", 32'(out_err), 32'd0);

      // Randomized traffic with random back-pressure.
      or_mode = 2;
      for (int t = 0; t < 150; t++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 4) == 0) ra = 16'd0;
         if ($urandom_range(0, 4) == 0) rb = 16'd0;
         rl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
         send(ra, rb, rl, int'($urandom_range(1, 4)), acc);
      end
      or_mode = 1;
      repeat (60) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
